mem_port_arbiter: RTL and testbench

Arbitrates a single-port unified memory between the fetch stage (instruction read) and the memory-access stage (load/store) of the 5-stage pipeline. The block latches one request, drives the shared memory port until the memory signals ready, then returns a one-cycle acknowledge to the winning requester. It raises per-requester stall signals, which feed the pipeline pause logic. Data requests have priority, with a bounded-streak rule that prevents instruction fetch starvation.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins ties, but a waiting fetch is granted after MAX_DSTREAK data grants in a row.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    output logic          if_stall,
    input  logic          me_req,
    input  logic          me_we,
    input  logic [1:0]    me_len,
    input  logic [AW-1:0] me_addr,
    input  logic [DW-1:0] me_wdata,
    output logic [DW-1:0] me_rdata,
    output logic          me_ack,
    output logic          me_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_len,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [1:0]    mem_len_q, mem_len_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] me_rdata_q, me_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          me_ack_q, me_ack_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_len_d   = mem_len_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        if_ack_d    = 1'b0;
        me_ack_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (me_req && (!if_req || (streak_q < STREAK_MAX))) begin
                    // Streak only grows while a fetch is actually being held off
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = me_we;
                    mem_len_d   = me_len;
                    mem_addr_d  = me_addr;
                    mem_wdata_d = me_wdata;
                    state_d     = DBUSY;
                end else if (if_req) begin
                    streak_d   = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_len_d  = 2'b10;
                    mem_addr_d = if_addr;
                    state_d    = IBUSY;
                end
            end
            IBUSY: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    state_d    = DONE;
                end
            end
            DBUSY: begin
                if (mem_ready) begin
                    me_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    me_ack_d   = 1'b1;
                    state_d    = DONE;
                end
            end
            // The served requester still holds req here, so no grant is made
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_len_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            me_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_len_q   <= mem_len_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
            if_ack_q    <= if_ack_d;
            me_ack_q    <= me_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_len   = mem_len_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign me_rdata  = me_rdata_q;
    assign if_ack    = if_ack_q;
    assign me_ack    = me_ack_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign me_stall  = me_req & ~me_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a cycle-by-cycle reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          me_req;
    logic          me_we;
    logic [1:0]    me_len;
    logic [AW-1:0] me_addr;
    logic [DW-1:0] me_wdata;
    logic [DW-1:0] me_rdata;
    logic          me_ack;
    logic          me_stall;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_len;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .me_req(me_req), .me_we(me_we), .me_len(me_len), .me_addr(me_addr),
        .me_wdata(me_wdata), .me_rdata(me_rdata), .me_ack(me_ack), .me_stall(me_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: who owns the port, what was latched, who is acked now
    bit          m_valid = 1'b0;
    bit          m_open;
    int          m_who;
    int          m_ack_who;
    int          m_streak;
    logic        m_we;
    logic [1:0]  m_len;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_me_rdata;
    int          last_ack_who = 0;

    typedef struct packed {
        logic        ifr;
        logic [31:0] ifa;
        logic        mer;
        logic        mwe;
        logic [1:0]  mlen;
        logic [31:0] mea;
        logic [31:0] mwd;
        logic        rdy;
        logic [31:0] rdat;
        logic        e_mreq;
        logic        e_mwe;
        logic [1:0]  e_mlen;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_ifack;
        logic        e_meack;
        logic        e_ifst;
        logic        e_mest;
        logic [31:0] e_ifrd;
        logic [31:0] e_merd;
    } vec_t;

    vec_t tbl [14];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        if (!m_valid) return;
        check_output("model mem_req", 64'(mem_req), 64'(m_open));
        check_output("model if_ack", 64'(if_ack), 64'(m_ack_who == 1));
        check_output("model me_ack", 64'(me_ack), 64'(m_ack_who == 2));
        check_output("model if_stall", 64'(if_stall), 64'(if_req & (m_ack_who != 1)));
        check_output("model me_stall", 64'(me_stall), 64'(me_req & (m_ack_who != 2)));
        check_output("model if_rdata", 64'(if_rdata), 64'(m_if_rdata));
        check_output("model me_rdata", 64'(me_rdata), 64'(m_me_rdata));
        if (m_open) begin
            check_output("model mem_we", 64'(mem_we), 64'(m_we));
            check_output("model mem_len", 64'(mem_len), 64'(m_len));
            check_output("model mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_who == 2) check_output("model mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    endtask

    task automatic model_step();
        int nxt_ack;
        if (rst) begin
            m_valid = 1'b1; m_open = 1'b0; m_who = 0; m_ack_who = 0; m_streak = 0;
            m_we = 1'b0; m_len = 2'd0; m_addr = '0; m_wdata = '0;
            m_if_rdata = '0; m_me_rdata = '0;
            return;
        end
        if (!m_valid) return;
        nxt_ack = 0;
        if (m_open) begin
            if (mem_ready) begin
                if (m_who == 1) m_if_rdata = mem_rdata;
                else            m_me_rdata = mem_rdata;
                m_open  = 1'b0;
                nxt_ack = m_who;
            end
        end else if (m_ack_who == 0) begin
            if (me_req && (!if_req || m_streak < MAXS)) begin
                m_streak = if_req ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
                m_who = 2; m_open = 1'b1;
                m_we = me_we; m_len = me_len; m_addr = me_addr; m_wdata = me_wdata;
            end else if (if_req) begin
                m_streak = 0;
                m_who = 1; m_open = 1'b1;
                m_we = 1'b0; m_len = 2'b10; m_addr = if_addr;
            end
        end
        m_ack_who = nxt_ack;
    endtask

    task automatic sample();
        @(negedge clk);
        model_compare();
        last_ack_who = m_ack_who;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        me_req = 1'b0; me_we = 1'b0; me_len = 2'd0; me_addr = '0; me_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            sample();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        if_req = v.ifr; if_addr = v.ifa;
        me_req = v.mer; me_we = v.mwe; me_len = v.mlen; me_addr = v.mea; me_wdata = v.mwd;
        mem_ready = v.rdy; mem_rdata = v.rdat;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ev [6];
        int ev_exp [6];
        int events;

        //         ifr   ifa          mer   mwe   mlen  mea           mwd             rdy   rdat
        //         emreq emwe  emlen  emaddr        emwd            ifack meack ifst  mest  ifrd           merd
        tbl[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h2408000A,
                    1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h2408000A,
                    1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h2408000A,
                    1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2408000A, 32'h0};
        tbl[3]  = '{1'b0, 32'h40, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h2408000A,
                    1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2408000A, 32'h0};
        tbl[4]  = '{1'b1, 32'h44, 1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h11111111,
                    1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2408000A, 32'h0};
        tbl[5]  = '{1'b1, 32'h44, 1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h11111111,
                    1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2408000A, 32'h0};
        tbl[6]  = '{1'b1, 32'h44, 1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h11111111,
                    1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2408000A, 32'h11111111};
        tbl[7]  = '{1'b1, 32'h44, 1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h22222222,
                    1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2408000A, 32'h11111111};
        tbl[8]  = '{1'b1, 32'h44, 1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h22222222,
                    1'b1, 1'b0, 2'd2, 32'h44, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2408000A, 32'h11111111};
        tbl[9]  = '{1'b1, 32'h44, 1'b0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 1'b1, 32'h22222222,
                    1'b0, 1'b0, 2'd2, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22222222, 32'h11111111};
        tbl[10] = '{1'b0, 32'h44, 1'b1, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b0, 32'h33333333,
                    1'b0, 1'b0, 2'd2, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 32'h11111111};
        tbl[11] = '{1'b0, 32'h44, 1'b1, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b1, 32'h33333333,
                    1'b1, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 32'h11111111};
        tbl[12] = '{1'b0, 32'h44, 1'b1, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b1, 32'h33333333,
                    1'b0, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22222222, 32'h33333333};
        tbl[13] = '{1'b0, 32'h44, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b1, 2'd0, 32'h103, 32'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 32'h33333333};

        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        sample();
        advance();

        // Reset state, observed while rst is still held
        sample();
        check_output("reset mem_req", 64'(mem_req), 64'(0));
        check_output("reset mem_we", 64'(mem_we), 64'(0));
        check_output("reset mem_len", 64'(mem_len), 64'(0));
        check_output("reset mem_addr", 64'(mem_addr), 64'(0));
        check_output("reset mem_wdata", 64'(mem_wdata), 64'(0));
        check_output("reset if_rdata", 64'(if_rdata), 64'(0));
        check_output("reset me_rdata", 64'(me_rdata), 64'(0));
        check_output("reset if_ack", 64'(if_ack), 64'(0));
        check_output("reset me_ack", 64'(me_ack), 64'(0));
        advance();
        rst = 1'b0;

        // Vector table: lone fetch, simultaneous requests, byte store
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i]);
            sample();
            check_output($sformatf("row%0d mem_req", i), 64'(mem_req), 64'(tbl[i].e_mreq));
            check_output($sformatf("row%0d mem_we", i), 64'(mem_we), 64'(tbl[i].e_mwe));
            check_output($sformatf("row%0d mem_len", i), 64'(mem_len), 64'(tbl[i].e_mlen));
            check_output($sformatf("row%0d mem_addr", i), 64'(mem_addr), 64'(tbl[i].e_maddr));
            if (tbl[i].e_mwe)
                check_output($sformatf("row%0d mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_mwd));
            check_output($sformatf("row%0d if_ack", i), 64'(if_ack), 64'(tbl[i].e_ifack));
            check_output($sformatf("row%0d me_ack", i), 64'(me_ack), 64'(tbl[i].e_meack));
            check_output($sformatf("row%0d if_stall", i), 64'(if_stall), 64'(tbl[i].e_ifst));
            check_output($sformatf("row%0d me_stall", i), 64'(me_stall), 64'(tbl[i].e_mest));
            check_output($sformatf("row%0d if_rdata", i), 64'(if_rdata), 64'(tbl[i].e_ifrd));
            check_output($sformatf("row%0d me_rdata", i), 64'(me_rdata), 64'(tbl[i].e_merd));
            advance();
        end

        // Starvation bound: 4 data acks, one fetch, then data again
        reset_dut();
        if_req = 1'b1; if_addr = 32'h200;
        me_req = 1'b1; me_we = 1'b0; me_len = 2'd2; me_addr = 32'h400;
        mem_ready = 1'b1; mem_rdata = 32'h5;
        ev_exp = '{2, 2, 2, 2, 1, 2};
        events = 0;
        for (int i = 0; i < 6; i++) ev[i] = 0;
        for (int c = 0; c < 40 && events < 6; c++) begin
            sample();
            if (if_ack) begin ev[events] = 1; events++; end
            if (me_ack && events < 6) begin ev[events] = 2; events++; end
            advance();
        end
        check_output("starve event count", 64'(events), 64'(6));
        for (int i = 0; i < 6; i++)
            check_output($sformatf("starve ack%0d (1=fetch 2=data)", i), 64'(ev[i]), 64'(ev_exp[i]));

        // Wait states: five cycles of mem_ready low
        reset_dut();
        me_req = 1'b1; me_we = 1'b0; me_len = 2'd1; me_addr = 32'h302;
        sample();
        check_output("wait c0 mem_req", 64'(mem_req), 64'(0));
        advance();
        for (int i = 0; i < 5; i++) begin
            sample();
            check_output("wait mem_req", 64'(mem_req), 64'(1));
            check_output("wait mem_addr", 64'(mem_addr), 64'(32'h302));
            check_output("wait mem_len", 64'(mem_len), 64'(1));
            check_output("wait mem_we", 64'(mem_we), 64'(0));
            check_output("wait me_stall", 64'(me_stall), 64'(1));
            check_output("wait me_ack", 64'(me_ack), 64'(0));
            advance();
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        sample();
        check_output("wait ready mem_req", 64'(mem_req), 64'(1));
        check_output("wait ready me_ack", 64'(me_ack), 64'(0));
        advance();
        mem_ready = 1'b0; mem_rdata = '0;
        sample();
        check_output("wait me_ack", 64'(me_ack), 64'(1));
        check_output("wait me_rdata", 64'(me_rdata), 64'(32'hCAFEF00D));
        check_output("wait me_stall at ack", 64'(me_stall), 64'(0));
        check_output("wait mem_req after", 64'(mem_req), 64'(0));
        advance();
        me_req = 1'b0;
        sample();
        check_output("wait ack pulse width", 64'(me_ack), 64'(0));
        advance();

        // Reset in the middle of a data access
        reset_dut();
        me_req = 1'b1; me_we = 1'b1; me_len = 2'd2; me_addr = 32'h500; me_wdata = 32'h12345678;
        sample();
        advance();
        sample();
        check_output("abort busy mem_req", 64'(mem_req), 64'(1));
        advance();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        sample();
        check_output("abort mem_req", 64'(mem_req), 64'(0));
        check_output("abort me_ack", 64'(me_ack), 64'(0));
        check_output("abort me_stall", 64'(me_stall), 64'(1));
        advance();
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        sample();
        check_output("abort regrant mem_req", 64'(mem_req), 64'(1));
        check_output("abort regrant mem_addr", 64'(mem_addr), 64'(32'h500));
        check_output("abort regrant mem_we", 64'(mem_we), 64'(1));
        check_output("abort regrant me_ack", 64'(me_ack), 64'(0));
        advance();
        mem_ready = 1'b0;
        sample();
        check_output("abort regrant ack", 64'(me_ack), 64'(1));
        advance();
        me_req = 1'b0;
        sample();
        advance();

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (last_ack_who == 1 || !if_req) begin
                if_req = (last_ack_who == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                if (if_req) if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (last_ack_who == 2 || !me_req) begin
                me_req = (last_ack_who == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                if (me_req) begin
                    me_we    = 1'($urandom_range(0, 1));
                    me_len   = 2'($urandom_range(0, 2));
                    me_addr  = $urandom;
                    me_wdata = $urandom;
                end
            end
            mem_ready = ($urandom_range(0, 99) < 60);
            mem_rdata = $urandom;
            sample();
            advance();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
